rr_arbiter_8: RTL and testbench
===============================

// Module: rr_arbiter_8
// PURPOSE
//  8-requester round-robin arbiter that shares a single downstream resource between requesters.
//  It issues a one-hot grant plus its 3-bit binary index, using the same bit-i -> i mapping as the 8-to-3 encoders.
//  A grant is held until the owner releases it.
//  It sits between requesters and the shared datapath; gnt_idx drives the datapath's select/mux input.
// PARAMETERS
//  N_REQ           8    number of requesters; fixed at 8, do not override
//  IDX_W           3    width of gnt_idx; equals log2(N_REQ)
//  TIMEOUT_CYCLES  16   maximum grant hold length in cycles, range 2..255; used only when GRANT_TIMEOUT_EN is defined
// PORTS
//  clk          in   1      rising-edge clock; the only clock
//  rst          in   1      reset; synchronous, active-high
//  req          in   8      request vector; bit i is high while requester i wants or holds the resource
//  done         in   1      release strobe from the current owner; sampled only while gnt_valid=1
//  gnt          out  8      one-hot grant, registered; all zeros when there is no owner
//  gnt_idx      out  3      binary index of the set bit in gnt; holds 3'b000 when gnt_valid=0
//  gnt_valid    out  1      high while a grant is active; equals |gnt
//  timeout_err  out  1      one-cycle pulse when a grant is forcibly revoked
// BEHAVIOUR
//  Reset (rst=1 at a clk edge): state=IDLE, ptr=3'd0, gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, timeout_err=0, hold counter=0.
//  Reset has priority over all other inputs. Reset mid-grant drops gnt at that same edge, with no release handshake.
//  FSM has 2 states.
//   IDLE:
//    - req==0: stay in IDLE.
//    - otherwise pick the first set req bit, searching circularly from ptr upward (7 wraps to 0).
//    - next edge: load gnt/gnt_idx/gnt_valid, set ptr = (winner+1) mod 8, go to GRANT.
//    - latency from req sampled high to gnt high = 1 cycle.
//   GRANT:
//    - release when done=1, or when req[gnt_idx]=0, sampled at an edge.
//    - at the release edge: gnt=0, gnt_valid=0, gnt_idx=0, state=IDLE.
//    - no release: gnt/gnt_idx held unchanged. Other req bits changing has no effect on the current grant.
//  Back-to-back: a release always forces one IDLE cycle (gnt=0) before the next grant.
//   - Minimum grant-to-grant spacing is grant length + 1 cycle.
//  Fairness: the winner is always re-ranked lowest. With all 8 requesting continuously, order is 0,1,..,7,0,...
//  done while in IDLE is ignored and has no side effects. done and a dropped req in the same cycle give a single release.
//  Invariants:
//   - gnt is always zero or exactly one-hot.
//   - gnt == (8'b1 << gnt_idx) whenever gnt_valid=1.
//   - gnt_idx never changes while in GRANT.
//  Arithmetic: ptr and gnt_idx are 3-bit and wrap modulo 8. Hold counter is 8-bit, saturating, cleared on entry to GRANT.
// CONFIGURATION
//  Macro GRANT_TIMEOUT_EN.
//  Defined:
//   - the hold counter increments each cycle in GRANT.
//   - if the grant reaches TIMEOUT_CYCLES cycles without release, the next edge forces a release.
//   - that release behaves exactly like a normal one (gnt=0, IDLE), and timeout_err=1 for exactly that one cycle.
//   - ptr is unchanged by the revoke; it already points past the revoked owner.
//   - a normal release in the same cycle as the timeout takes precedence: no timeout_err.
//  Not defined:
//   - no hold counter is built; timeout_err is tied to 0.
//   - a grant is held indefinitely until done or req drop.
// TESTING
//  T1 single:
//   - after reset, req=8'b0000_0100 -> next cycle gnt=8'b0000_0100, gnt_idx=3'd2, gnt_valid=1.
//   - pulse done -> gnt=0 the following cycle.
//  T2 rotation:
//   - req=8'hFF held, done pulsed 1 cycle after each grant -> gnt_idx sequence 0,1,2,...,7,0.
//   - each grant is separated by exactly one gnt=0 cycle.
//  T3 wrap/skip:
//   - grant 7 completes, then req=8'b0000_0011 -> gnt_idx=0.
//   - with ptr=3, req=8'b0000_0110 -> gnt_idx=1.
//  T4 req drop:
//   - owner 5 deasserts req[5] with done=0 -> gnt=0 at the next edge.
//   - req[6] pending -> gnt_idx=6 one cycle later.
//  T5 reset/ignore:
//   - done pulsed in IDLE -> no change.
//   - rst=1 during grant to 4 -> gnt=0 at the same edge; next arbitration starts from ptr=0.
//  T6 timeout (macro defined, TIMEOUT_CYCLES=4):
//   - owner 2 never releases -> gnt high exactly 4 cycles, then gnt=0 and timeout_err=1 for 1 cycle.
//   - next grant goes to 3. Without the macro, gnt is still held after 100 cycles.

Source files
------------

// File: rtl/rr_arbiter_8.sv
// 8-requester round-robin arbiter with a hold-until-release grant and a one-hot plus binary grant output.
// Optional grant timeout (forced revoke with timeout_err pulse) is enabled by defining GRANT_TIMEOUT_EN.
module rr_arbiter_8 #(
    parameter int N_REQ          = 8,
    parameter int IDX_W          = 3,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout_err
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] ptr_reg, ptr_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [N_REQ-1:0] gnt_reg, gnt_next;
    logic [N_REQ-1:0] rot_req;
    logic [IDX_W-1:0] rot_pos;
    logic [IDX_W-1:0] winner;
    logic             release_now;
    logic             expire;

    // Rotate the request vector so bit 0 is the requester at ptr; the lowest set bit then wins.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
            assign rot_req[gi] = req[ptr_reg + IDX_W'(gi)];
        end
    endgenerate

    always_comb begin
        rot_pos = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot_req[i]) rot_pos = IDX_W'(i);
        end
    end

    assign winner      = ptr_reg + rot_pos;
    assign release_now = done || !req[idx_reg];

`ifdef GRANT_TIMEOUT_EN
    logic [7:0] hold_reg, hold_next;
    logic       terr_reg;

    assign expire = (state_reg == GRANT) && !release_now && (hold_reg == 8'(TIMEOUT_CYCLES - 1));

    // Counter sits at zero in IDLE, so it is already cleared on entry to GRANT.
    always_comb begin
        hold_next = 8'd0;
        if (state_reg == GRANT && hold_reg != 8'hFF) hold_next = hold_reg + 8'd1;
        else if (state_reg == GRANT)                 hold_next = hold_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_reg <= 8'd0;
            terr_reg <= 1'b0;
        end else begin
            hold_reg <= hold_next;
            terr_reg <= expire;
        end
    end

    assign timeout_err = terr_reg;
`else
    // Out-of-range settings leave an empty marker block; the timeout logic is not built here.
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_timeout_unused
    end
    assign expire      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            idx_reg   <= '0;
            gnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            idx_reg   <= idx_next;
            gnt_reg   <= gnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        idx_next   = idx_reg;
        gnt_next   = gnt_reg;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    state_next = GRANT;
                    idx_next   = winner;
                    gnt_next   = N_REQ'(1) << winner;
                    ptr_next   = winner + IDX_W'(1);
                end
            end
            GRANT: begin
                // A normal release and a timeout revoke share one path; ptr already points past the owner.
                if (release_now || expire) begin
                    state_next = IDLE;
                    idx_next   = '0;
                    gnt_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
                gnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        gnt       = gnt_reg;
        gnt_idx   = idx_reg;
        gnt_valid = (state_reg == GRANT);
    end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Randomized and directed bench for rr_arbiter_8 against a behavioural round-robin model.
// Timeout scenarios follow the GRANT_TIMEOUT_EN macro of the build.
module tb_rr_arbiter_8;

    localparam int TO = 4;
`ifdef GRANT_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic       done = 1'b0;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout_err;

    int n_cmp = 0;
    int n_err = 0;
    int cycle = 0;

    // Model state: current owner (-1 = none), rotation start, hold length, revoke flag.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;
    bit m_terr  = 1'b0;

    rr_arbiter_8 #(.N_REQ(8), .IDX_W(3), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .gnt         (gnt),
        .gnt_idx     (gnt_idx),
        .gnt_valid   (gnt_valid),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cycle, obs, exp);
        end
    endtask

    task automatic model_edge(input logic [7:0] r, input logic d, input logic rs);
        bit found;
        if (rs) begin
            m_owner = -1; m_ptr = 0; m_hold = 0; m_terr = 1'b0;
        end else if (m_owner >= 0) begin
            m_terr = 1'b0;
            if (d || !r[m_owner]) begin
                m_owner = -1;
            end else if (TIMEOUT_ON && m_hold == TO - 1) begin
                m_owner = -1;
                m_terr  = 1'b1;
            end else if (m_hold < 255) begin
                m_hold++;
            end
        end else begin
            m_terr = 1'b0;
            found  = 1'b0;
            for (int k = 0; k < 8; k++) begin
                int i;
                i = (m_ptr + k) % 8;
                if (!found && r[i]) begin
                    found   = 1'b1;
                    m_owner = i;
                    m_hold  = 0;
                end
            end
            if (found) m_ptr = (m_owner + 1) % 8;
        end
    endtask

    task automatic step(input logic [7:0] r, input logic d, input logic rs);
        int prev_owner;
        logic [7:0] e_gnt;
        @(negedge clk);
        req = r; done = d; rst = rs;
        prev_owner = m_owner;
        model_edge(r, d, rs);
        @(posedge clk);
        #1;
        cycle++;
        e_gnt = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
        chk("gnt", 32'(gnt), 32'(e_gnt));
        chk("gnt_idx", 32'(gnt_idx), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        chk("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
        chk("timeout_err", 32'(timeout_err), 32'(m_terr));
        if (m_owner >= 0 && prev_owner < 0)
            $display("cycle %0d: req=%02h grant -> %0d", cycle, r, m_owner);
        else if (m_terr)
            $display("cycle %0d: grant revoked by timeout", cycle);
    endtask

    initial begin
        logic [7:0] r;
        // Reset state
        step(8'h00, 1'b0, 1'b1);
        step(8'h00, 1'b0, 1'b1);
        chk("reset_gnt", 32'(gnt), 32'd0);
        chk("reset_valid", 32'(gnt_valid), 32'd0);

        // Single request and release
        step(8'h04, 1'b0, 1'b0);
        chk("t1_gnt", 32'(gnt), 32'h04);
        chk("t1_idx", 32'(gnt_idx), 32'd2);
        step(8'h04, 1'b1, 1'b0);
        chk("t1_release", 32'(gnt), 32'd0);

        // done in IDLE is ignored
        step(8'h00, 1'b1, 1'b0);
        chk("t5_idle_done", 32'(gnt_valid), 32'd0);

        // Full rotation from ptr=0 with one idle cycle between grants
        step(8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(8'hFF, 1'b0, 1'b0);
            chk("t2_idx", 32'(gnt_idx), 32'(i));
            step(8'hFF, 1'b1, 1'b0);
            chk("t2_gap", 32'(gnt), 32'd0);
        end

        // Wrap after 7, then skip from ptr=3 around to 1
        step(8'h03, 1'b0, 1'b0);
        chk("t3_wrap", 32'(gnt_idx), 32'd0);
        step(8'h03, 1'b1, 1'b0);
        step(8'h04, 1'b0, 1'b0);
        step(8'h04, 1'b1, 1'b0);
        step(8'h06, 1'b0, 1'b0);
        chk("t3_skip", 32'(gnt_idx), 32'd1);
        step(8'h06, 1'b1, 1'b0);

        // Request drop releases owner 5, then 6 is served
        step(8'h60, 1'b0, 1'b0);
        chk("t4_owner", 32'(gnt_idx), 32'd5);
        step(8'h40, 1'b0, 1'b0);
        chk("t4_drop", 32'(gnt), 32'd0);
        step(8'h40, 1'b0, 1'b0);
        chk("t4_next", 32'(gnt_idx), 32'd6);
        step(8'h40, 1'b1, 1'b0);

        // Reset during a grant drops it at once and restarts from ptr=0
        step(8'h10, 1'b0, 1'b0);
        chk("t5_owner", 32'(gnt_idx), 32'd4);
        step(8'h10, 1'b0, 1'b1);
        chk("t5_rst_drop", 32'(gnt), 32'd0);
        step(8'hFF, 1'b0, 1'b0);
        chk("t5_ptr0", 32'(gnt_idx), 32'd0);
        step(8'hFF, 1'b1, 1'b0);

        // Timeout: owner 2 never releases
        step(8'h00, 1'b0, 1'b1);
        step(8'h0C, 1'b0, 1'b0);
        if (TIMEOUT_ON) begin
            for (int i = 0; i < TO - 1; i++) step(8'h0C, 1'b0, 1'b0);
            chk("t6_held", 32'(gnt), 32'h04);
            step(8'h0C, 1'b0, 1'b0);
            chk("t6_revoke", 32'(gnt), 32'd0);
            chk("t6_terr", 32'(timeout_err), 32'd1);
            step(8'h0C, 1'b0, 1'b0);
            chk("t6_next", 32'(gnt_idx), 32'd3);
            chk("t6_terr_pulse", 32'(timeout_err), 32'd0);
        end else begin
            for (int i = 0; i < 100; i++) step(8'h0C, 1'b0, 1'b0);
            chk("t6_held_100", 32'(gnt), 32'h04);
        end
        step(8'h0C, 1'b1, 1'b0);

        // Randomized traffic with sticky requests and occasional resets
        r = 8'($urandom);
        for (int i = 0; i < 2000; i++) begin
            r = r ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            step(r, ($urandom_range(0, 5) == 0), ($urandom_range(0, 199) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
